// File: rtl/fmul_pkg.sv
// Shared fp16 multiply-issue types and constants for the scoreboard machine.
package fmul_pkg;

  localparam int FP16_W       = 16;
  localparam int FP16_SIGN    = 15;
  localparam int FP16_EXP_MSB = 14;
  localparam int FP16_EXP_LSB = 10;
  localparam int FP16_MAN_MSB = 9;
  localparam int FP16_MAN_LSB = 0;
  localparam int FP16_BIAS    = 15;

  // Records are sized for the widest legal configuration (8 requesters,
  // 8-bit tags); narrower instances zero-extend on capture.
  localparam int TAG_MAX_W = 8;
  localparam int SRC_MAX_W = 3;

  typedef struct packed {
    logic [FP16_W-1:0]    a;
    logic [FP16_W-1:0]    b;
    logic [TAG_MAX_W-1:0] tag;
  } fmul_req_t;

  typedef struct packed {
    logic [FP16_W-1:0]    data;
    logic [TAG_MAX_W-1:0] tag;
    logic [SRC_MAX_W-1:0] src;
  } fmul_res_t;

endpackage

// File: rtl/fmul_issue_arbiter_if.sv
// Request / multiplier / writeback bundle of the shared fp16 multiplier.
interface fmul_issue_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
);
  import fmul_pkg::*;
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][FP16_W-1:0] req_a;
  logic [NUM_REQ-1:0][FP16_W-1:0] req_b;
  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0]             req_ready;
  logic [FP16_W-1:0]              mul_a;
  logic [FP16_W-1:0]              mul_b;
  logic [FP16_W-1:0]              mul_o;
  logic                           res_valid;
  logic [FP16_W-1:0]              res_data;
  logic [TAG_W-1:0]               res_tag;
  logic [SRC_W-1:0]               res_src;
  logic                           res_ready;

  modport slave (
    input  req_valid, req_a, req_b, req_tag, mul_o, res_ready,
    output req_ready, mul_a, mul_b, res_valid, res_data, res_tag, res_src
  );

  modport master (
    output req_valid, req_a, req_b, req_tag, mul_o, res_ready,
    input  req_ready, mul_a, mul_b, res_valid, res_data, res_tag, res_src
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: search starts at the pointer, which moves past the
// winner only when the grant is actually taken (adv && any request).
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       adv,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;

  // first set request at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        idx      = j;
        found    = 1'b1;
      end
    end
  end

  // pointer moves one past the winner on every taken grant
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (adv && |req)
      ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/fmul_issue_arbiter.sv
// Shares one combinational fp16 multiplier among NUM_REQ requesters.
// Round-robin issue into a LATENCY-deep delay pipe with whole-pipe stall on
// result backpressure. Optional FMUL_ARB_STATS_EN adds issue/stall counters.
module fmul_issue_arbiter
  import fmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 4
) (
  input logic clk,
  input logic rst,
  fmul_issue_arbiter_if.slave bus
`ifdef FMUL_ARB_STATS_EN
  ,
  output logic [31:0] stat_issue_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);
  localparam int SRC_W  = $clog2(NUM_REQ);
  localparam int STAGES = LATENCY - 1;

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   win;
  logic               advance;
  logic               issue;

  logic [STAGES:0]      vld_pipe;
  fmul_req_t            s0;
  logic [SRC_MAX_W-1:0] s0_src;
  fmul_res_t            pipe [STAGES:1];

  assign advance = !(vld_pipe[STAGES] && !bus.res_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (bus.req_valid),
    .adv   (advance),
    .grant (grant),
    .idx   (win)
  );

  // grant only while the pipe can move and never during reset
  always_comb begin
    bus.req_ready = '0;
    if (!rst && advance)
      bus.req_ready = grant;
  end

  assign issue = |(bus.req_valid & bus.req_ready);

  // stage 0 captures the winner's operands (or a bubble); later stages carry
  // the product; everything freezes together while the result is blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s0       <= '0;
      s0_src   <= '0;
      for (int k = 1; k <= STAGES; k++)
        pipe[k] <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      if (issue) begin
        s0.a   <= bus.req_a[win];
        s0.b   <= bus.req_b[win];
        s0.tag <= TAG_MAX_W'(bus.req_tag[win]);
        s0_src <= SRC_MAX_W'(win);
      end
      pipe[1].data <= bus.mul_o;
      pipe[1].tag  <= s0.tag;
      pipe[1].src  <= s0_src;
      for (int k = 2; k <= STAGES; k++)
        pipe[k] <= pipe[k-1];
    end
  end

  assign bus.mul_a     = s0.a;
  assign bus.mul_b     = s0.b;
  assign bus.res_valid = vld_pipe[STAGES];
  assign bus.res_data  = pipe[STAGES].data;
  assign bus.res_tag   = TAG_W'(pipe[STAGES].tag);
  assign bus.res_src   = SRC_W'(pipe[STAGES].src);

`ifdef FMUL_ARB_STATS_EN
  // free-running wrap counters of issues and of cycles a request was blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (issue)
        stat_issue_cnt <= stat_issue_cnt + 32'd1;
      if (!advance && |bus.req_valid)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// Self-checking bench for fmul_issue_arbiter: a queue-based reference model
// with per-item countdowns plus directed scenarios from the feature list.
module tb_fmul_issue_arbiter;
  import fmul_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int TW  = 4;

  logic clk;
  logic rst;

  fmul_issue_arbiter_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

`ifdef FMUL_ARB_STATS_EN
  logic [31:0] stat_issue_cnt, stat_stall_cnt;
  int m_issue, m_stall;
`endif

  fmul_issue_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FMUL_ARB_STATS_EN
    ,
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural fp16 multiplier (truncating, flush-to-zero, saturate to inf)
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int e;
    logic [21:0] p;
    logic [9:0] m;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'h0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin m = p[20:11]; e = e + 1; end
    else m = p[19:10];
    if (e >= 31) return {s, 5'h1f, 10'h0};
    if (e <= 0) return {s, 15'h0};
    return {s, e[4:0], m};
  endfunction

  assign bus.mul_o = fp16_mul(bus.mul_a, bus.mul_b);

  typedef struct {
    fmul_res_t r;
    int        rem;
  } ent_t;

  ent_t q[$];
  int   ptr;
  int   last_grant;
  int   dut_out;
  int   n_chk;
  int   n_fail;

  task automatic new_op(input int i);
    bus.req_a[i]   = 16'($urandom());
    bus.req_b[i]   = 16'($urandom());
    bus.req_tag[i] = 4'($urandom());
  endtask

  // one clock: check outputs against the model, then advance the model
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] rv;
    logic vis, adv;
    int win;
    ent_t e;
    #1;
    vis = (q.size() > 0) && (q[0].rem == 0);
    adv = !(vis && !bus.res_ready);
    win = -1;
    if (!rst && adv)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (win < 0 && bus.req_valid[j]) win = j;
      end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    n_chk++;
    if (bus.req_ready !== exp_rdy) begin
      n_fail++; $display("FAIL req_ready: got %b exp %b", bus.req_ready, exp_rdy);
    end
    n_chk++;
    if (bus.res_valid !== vis) begin
      n_fail++; $display("FAIL res_valid: got %b exp %b", bus.res_valid, vis);
    end
    if (vis) begin
      n_chk++;
      if ({bus.res_data, TAG_MAX_W'(bus.res_tag), SRC_MAX_W'(bus.res_src)} !== q[0].r) begin
        n_fail++;
        $display("FAIL result: got data=%h tag=%h src=%0d exp data=%h tag=%h src=%0d",
                 bus.res_data, bus.res_tag, bus.res_src, q[0].r.data, q[0].r.tag, q[0].r.src);
      end
    end
    if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) dut_out++;
    last_grant = win;
    rv = bus.req_valid;
    if (win >= 0) begin
      e.r.data = fp16_mul(bus.req_a[win], bus.req_b[win]);
      e.r.tag  = TAG_MAX_W'(bus.req_tag[win]);
      e.r.src  = SRC_MAX_W'(win);
      e.rem    = LAT - 1;
    end
    @(posedge clk);
    if (rst) begin
      q.delete(); ptr = 0; dut_out = 0;
`ifdef FMUL_ARB_STATS_EN
      m_issue = 0; m_stall = 0;
`endif
    end else begin
`ifdef FMUL_ARB_STATS_EN
      if (win >= 0) m_issue++;
      if (!adv && |rv) m_stall++;
`endif
      if (adv) begin
        if (vis) void'(q.pop_front());
        for (int k = 0; k < q.size(); k++) q[k].rem = q[k].rem - 1;
        if (win >= 0) begin
          q.push_back(e);
          ptr = (win + 1) % N;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 4 * LAT + 10; k++) begin
      if (q.size() == 0) break;
      cycle();
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL drain timeout: %0d results still outstanding, exp 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) new_op(i);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if ({bus.mul_a, bus.mul_b, bus.res_data, bus.res_tag, bus.res_src} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got mul_a=%h mul_b=%h data=%h tag=%h src=%h exp all 0",
               bus.mul_a, bus.mul_b, bus.res_data, bus.res_tag, bus.res_src);
    end
    n_chk++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b exp 0000", bus.req_ready);
    end
    cycle();
    rst = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_single_issue();
    int seen;
    bus.req_valid  = 4'b0001;
    bus.req_a[0]   = 16'h3E00;
    bus.req_b[0]   = 16'h4000;
    bus.req_tag[0] = 4'd5;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_grant: got %b exp 0001", bus.req_ready);
    end
    cycle();
    bus.req_valid = '0;
    seen = -1;
    for (int k = 0; k < LAT + 2; k++) begin
      #1;
      if (bus.res_valid === 1'b1 && seen < 0) begin
        seen = k;
        n_chk++;
        if (bus.res_data !== 16'h4200 || bus.res_tag !== 4'd5 || bus.res_src !== 2'd0) begin
          n_fail++;
          $display("FAIL single_result: got %h/%h/%h exp 4200/5/0", bus.res_data, bus.res_tag, bus.res_src);
        end
      end
      cycle();
    end
    n_chk++;
    if (seen != LAT - 1) begin
      n_fail++; $display("FAIL single_latency: got %0d extra cycles exp %0d", seen, LAT - 1);
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) new_op(i);
    for (int c = 0; c < 8; c++) begin
      #1;
      n_chk++;
      if (bus.req_ready !== 4'(1 << (c % N))) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b exp %b", c, bus.req_ready, 4'(1 << (c % N)));
      end
      cycle();
      if (last_grant >= 0) new_op(last_grant);
    end
    drain();
  endtask

  task automatic test_fairness();
    reset_dut();
    bus.req_valid = 4'b0011;
    for (int i = 0; i < N; i++) new_op(i);
    cycle();
    cycle();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if (bus.req_ready !== 4'(1 << c)) begin
        n_fail++; $display("FAIL fair_grant[%0d]: got %b exp %b", c, bus.req_ready, 4'(1 << c));
      end
      cycle();
      if (last_grant >= 0) new_op(last_grant);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] hd;
    logic [3:0]  ht;
    logic [1:0]  hs;
    int stalls;
    hd = '0; ht = '0; hs = '0;
    reset_dut();
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < N; i++) new_op(i);
    stalls = 0;
    for (int it = 0; it < 10; it++) begin
      #1;
      if (bus.res_valid === 1'b1 && stalls < 3) begin
        bus.res_ready = 1'b0;
        #1;
        if (stalls == 0) begin
          hd = bus.res_data; ht = bus.res_tag; hs = bus.res_src;
        end else begin
          n_chk++;
          if ({bus.res_data, bus.res_tag, bus.res_src} !== {hd, ht, hs}) begin
            n_fail++;
            $display("FAIL bp_stable: got %h/%h/%h exp %h/%h/%h",
                     bus.res_data, bus.res_tag, bus.res_src, hd, ht, hs);
          end
        end
        n_chk++;
        if (bus.req_ready !== 4'b0000) begin
          n_fail++; $display("FAIL bp_ready: got %b exp 0000", bus.req_ready);
        end
        stalls++;
      end else begin
        bus.res_ready = 1'b1;
      end
      cycle();
      if (last_grant >= 0) bus.req_valid[last_grant] = 1'b0;
    end
    drain();
    n_chk++;
    if (dut_out != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d results exp 4", dut_out);
    end
  endtask

  task automatic test_passthrough();
    logic [15:0] gd [2];
    logic [1:0]  gs [2];
    int ng;
    reset_dut();
    bus.req_a[2] = 16'h0000; bus.req_b[2] = 16'h3C00; bus.req_tag[2] = 4'd3;
    bus.req_a[3] = 16'hBC00; bus.req_b[3] = 16'h3C00; bus.req_tag[3] = 4'd7;
    bus.req_valid = 4'b1100;
    ng = 0;
    gd[0] = 'x; gd[1] = 'x; gs[0] = 'x; gs[1] = 'x;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1 && ng < 2) begin
        gd[ng] = bus.res_data; gs[ng] = bus.res_src; ng++;
      end
      cycle();
      if (last_grant >= 0) bus.req_valid[last_grant] = 1'b0;
    end
    n_chk++;
    if (ng != 2 || gd[0] !== 16'h0000 || gs[0] !== 2'd2) begin
      n_fail++; $display("FAIL zero_pass: got n=%0d %h src %0d exp 0000 src 2", ng, gd[0], gs[0]);
    end
    n_chk++;
    if (gd[1] !== 16'hBC00 || gs[1] !== 2'd3) begin
      n_fail++; $display("FAIL sign_pass: got %h src %0d exp bc00 src 3", gd[1], gs[1]);
    end
  endtask

  task automatic test_reset_midflight();
    reset_dut();
    bus.req_valid = 4'b0011;
    for (int i = 0; i < N; i++) new_op(i);
    cycle();
    cycle();
    bus.req_valid = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      #1;
      n_chk++;
      if (bus.res_valid !== 1'b0) begin
        n_fail++; $display("FAIL midflight_stale[%0d]: got res_valid=%b exp 0", k, bus.res_valid);
      end
      cycle();
    end
    bus.req_valid = '1;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL midflight_first: got %b exp 0001", bus.req_ready);
    end
    cycle();
    drain();
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < N; i++) new_op(i);
    bus.req_valid = 4'($urandom());
    for (int c = 0; c < 400; c++) begin
      bus.res_ready = ($urandom() % 4) != 0;
      cycle();
      for (int i = 0; i < N; i++)
        if (i == last_grant || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom() % 3) != 0;
          new_op(i);
        end
    end
`ifdef FMUL_ARB_STATS_EN
    #1;
    n_chk++;
    if (stat_issue_cnt !== 32'(m_issue) || stat_stall_cnt !== 32'(m_stall)) begin
      n_fail++;
      $display("FAIL stats: got issue=%0d stall=%0d exp issue=%0d stall=%0d",
               stat_issue_cnt, stat_stall_cnt, m_issue, m_stall);
    end
`endif
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; ptr = 0; last_grant = -1; dut_out = 0;
`ifdef FMUL_ARB_STATS_EN
    m_issue = 0; m_stall = 0;
`endif
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_tag = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_single_issue();
    test_round_robin();
    test_fairness();
    test_backpressure();
    test_passthrough();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fmul_issue_arbiter.md
Name: fmul_issue_arbiter

Overview:
Shares one combinational fp16 multiplier (`floatmul`-style datapath, 16-bit a/b/o) among NUM_REQ functional-unit requesters in the scoreboard machine. Round-robin arbitration issues at most one multiply per cycle. Operands are registered into a fixed-latency delay pipe, and results return tagged with requester index and destination tag for scoreboard writeback. The pipe supports result backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LATENCY, 3, cycles from issue handshake edge to res_valid (min 2)
TAG_W, 4, destination-register tag width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester request
req_a  in  16*NUM_REQ  operand A, slice i = [16i+15:16i]
req_b  in  16*NUM_REQ  operand B, same slicing
req_tag  in  TAG_W*NUM_REQ  destination tag per requester
req_ready  out  NUM_REQ  one-hot-or-zero grant
mul_a  out  16  operand A to multiplier
mul_b  out  16  operand B to multiplier
mul_o  in  16  combinational product from multiplier
res_valid  out  1  result valid
res_data  out  16  product
res_tag  out  TAG_W  tag of result
res_src  out  clog2(NUM_REQ)  requester index of result
res_ready  in  1  writeback consumer accepts result

Behaviour:
- Reset:
  - All pipe valid bits cleared; res_valid=0, res_data=0, res_tag=0, res_src=0.
  - mul_a=mul_b=0; RR pointer=0; req_ready=0 in the cycle rst is high.
- Reset mid-operation discards all in-flight multiplies; no result is emitted for them.
- advance = !(res_valid && !res_ready).
- Arbitration:
  - Search req_valid starting at the pointer, wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready[win]=advance; all other bits 0; req_ready may combinationally depend on req_valid.
  - Issue = req_valid[i] && req_ready[i] at a rising edge.
  - On issue, pointer <= (win+1) mod NUM_REQ; otherwise the pointer holds.
- Requesters hold valid, operands and tag stable until accepted; the arbiter never drops a request.
- Pipe:
  - Stage 0 registers A, B, tag, src and valid on issue. A bubble (valid=0) is loaded if there is no issue and advance=1.
  - mul_a/mul_b come directly from stage-0 registers.
  - Stage 1 captures mul_o; stages 2..LATENCY-1 delay the product.
  - The last stage drives res_*.
- Latency: issue at edge t gives res_valid=1 in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles.
- Throughput is 1 per cycle when res_ready stays high.
- Stall:
  - When advance=0, every stage including stage 0 holds, and no grant is made.
  - The stall is whole-pipe; bubbles are not collapsed.
- res_data, res_tag and res_src stay stable while res_valid && !res_ready.
- Result order equals issue order.
- Simultaneous events: a result drain (res_ready=1) and a new issue in the same cycle are both allowed.
- Single requester continuously valid is granted every cycle.
- Arithmetic (rounding, zero handling, overflow) lives entirely in the multiplier; this block never modifies operands or product.

Optional Feature:
FMUL_ARB_STATS_EN:
- Defined: adds output `stat_issue_cnt` (32 bits, wraps) incremented on every issue, and output `stat_stall_cnt` (32 bits, wraps) incremented each cycle advance=0 && |req_valid. Both reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `fmul_pkg`:
  - FP16_W=16 and fp16 field constants (sign bit 15, exponent [14:10], mantissa [9:0], bias 15).
  - `fmul_req_t` struct {a, b, tag}.
  - `fmul_res_t` struct {data, tag, src}.
- Sub-module `rr_arbiter` (NUM_REQ): inputs req, pointer-advance enable; outputs one-hot grant and index.
- The delay pipe stays inline.

Test Plan:
- Single issue: req_valid=0001, req_a[0]=0x3E00, req_b[0]=0x4000, tag=5 -> req_ready=0001; LATENCY cycles later res_valid=1, res_data=0x4200, res_tag=5, res_src=0.
- Round-robin: req_valid=1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; results in the same order.
- Fairness after partial: pointer at 2, req_valid=0011 -> grant 0, then 1.
- Backpressure: stream of 4 issues, res_ready=0 for 3 cycles once res_valid=1 -> res_* stable, req_ready=0 during the stall; all 4 results delivered after release, none lost or duplicated.
- Zero/sign passthrough: 0x0000*0x3C00 -> 0x0000; 0xBC00*0x3C00 -> 0xBC00.
- Reset mid-flight: 2 issues outstanding, rst=1 for one cycle -> res_valid stays 0 and no stale result appears; next issue is granted to requester 0 first.
